dst_drain: RTL and testbench

Result-side drain buffer for the exe stage. It captures accumulator words written during each `out_period` window at `out_addr`, and commits each window as one burst on `out_fin`. Committed bursts are streamed to the DMA/output side over a valid/ready interface with a last flag. Two banks (ping-pong) let one burst be written while the previous one drains.

---
 rtl/dst_drain.sv | 170 +++++++++++++++++
 tb/tb_dst_drain.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dst_drain.sv
// Ping-pong drain buffer: captures one accumulator burst per bank and streams
// committed bursts out over valid/ready with a last flag, in commit order.
module dst_drain #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          out_period,
    input  logic [AW-1:0] out_addr,
    input  logic          out_fin,
    input  logic [DW-1:0] acc_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [1:0]    pend,
    output logic          drain_busy,
    output logic          overflow
);

    localparam int DEPTH = 1 << AW;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [DW-1:0] mem_q [2][DEPTH];

    logic [1:0]    full_q, full_d;
    logic [AW:0]   len_q [2];
    logic [AW:0]   len_d [2];
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [AW:0]   hw_q, hw_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [0:0]    state_q, state_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic          overflow_q, overflow_d;

    logic          wr_en_s;
    logic [AW:0]   addr_p1_s;
    logic [AW:0]   mark_s;
    logic          commit_s;
    logic          release_s;
    logic [AW-1:0] nxt_idx_s;

    // Write side: hi-water mark tracking, commit decision and overflow detection
    always_comb begin
        wr_en_s    = out_period & ~full_q[wb_q];
        addr_p1_s  = {1'b0, out_addr} + {{AW{1'b0}}, 1'b1};
        mark_s     = (wr_en_s && (addr_p1_s > hw_q)) ? addr_p1_s : hw_q;
        commit_s   = out_fin & ~full_q[wb_q] & (mark_s != {(AW+1){1'b0}});
        overflow_d = overflow_q | ((out_period | out_fin) & full_q[wb_q]);
        // Every commit, empty commit or dropped burst restarts the mark
        hw_d       = out_fin ? {(AW+1){1'b0}} : mark_s;
        wb_d       = commit_s ? ~wb_q : wb_q;
    end

    // Read side FSM: load first word from a full bank, then step on handshakes
    always_comb begin
        state_d   = state_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        idx_d     = idx_q;
        rb_d      = rb_q;
        release_s = 1'b0;
        nxt_idx_s = idx_q + {{(AW-1){1'b0}}, 1'b1};
        case (state_q)
            ST_IDLE: begin
                if (full_q[rb_q]) begin
                    m_data_d  = mem_q[rb_q][{AW{1'b0}}];
                    m_valid_d = 1'b1;
                    m_last_d  = (len_q[rb_q] == {{AW{1'b0}}, 1'b1});
                    idx_d     = {AW{1'b0}};
                    state_d   = ST_SEND;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (m_valid_q && m_ready) begin
                    if (m_last_q) begin
                        release_s = 1'b1;
                        rb_d      = ~rb_q;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d     = nxt_idx_s;
                        m_data_d  = mem_q[rb_q][nxt_idx_s];
                        m_last_d  = (({1'b0, idx_q} + (AW+1)'(2'd2)) == len_q[rb_q]);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        endcase
    end

    // Bank occupancy: commit and release can hit opposite banks in one cycle
    always_comb begin
        full_d   = full_q;
        len_d[0] = len_q[0];
        len_d[1] = len_q[1];
        if (commit_s) begin
            full_d[wb_q] = 1'b1;
            len_d[wb_q]  = mark_s;
        end else begin
            full_d[wb_q] = full_q[wb_q];
        end
        if (release_s) begin
            full_d[rb_q] = 1'b0;
        end else begin
            full_d[rb_q] = full_d[rb_q];
        end
    end

    // Bank storage; contents survive reset and are only read after commit
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wb_q][out_addr] <= acc_data;
        end
    end

    // Control and output state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= 2'b00;
            len_q[0]   <= {(AW+1){1'b0}};
            len_q[1]   <= {(AW+1){1'b0}};
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            hw_q       <= {(AW+1){1'b0}};
            idx_q      <= {AW{1'b0}};
            state_q    <= ST_IDLE;
            m_data_q   <= {DW{1'b0}};
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            len_q[0]   <= len_d[0];
            len_q[1]   <= len_d[1];
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            hw_q       <= hw_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            overflow_q <= overflow_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign overflow   = overflow_q;
    assign drain_busy = (state_q == ST_SEND);
    assign pend       = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule

// File: tb/tb_dst_drain.sv
// Scoreboard bench for dst_drain: a burst-level model queues expected beats,
// an independent monitor pops and checks them on every handshake.
module tb_dst_drain;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          out_period;
    logic [AW-1:0] out_addr;
    logic          out_fin;
    logic [DW-1:0] acc_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [1:0]    pend;
    logic          drain_busy;
    logic          overflow;

    dst_drain #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_period (out_period),
        .out_addr   (out_addr),
        .out_fin    (out_fin),
        .acc_data   (acc_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .pend       (pend),
        .drain_busy (drain_busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t exp_q[$];
    int    lens[$];
    int    m_pend = 0;
    int    hs_cnt = 0;
    bit    m_ovf = 1'b0;
    int    mark = 0;
    logic [DW-1:0] wbuf [DEPTH];
    int    ready_mode = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: bursts, pending count and overflow, evaluated per clock edge
    initial begin : model
        bit wfull;
        int com;
        int rel;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                lens.delete();
                m_pend = 0;
                hs_cnt = 0;
                m_ovf  = 1'b0;
                mark   = 0;
            end else begin
                wfull = (m_pend == 2);
                com   = 0;
                rel   = 0;
                if (out_period) begin
                    if (wfull) m_ovf = 1'b1;
                    else begin
                        wbuf[out_addr] = acc_data;
                        if (int'(out_addr) + 1 > mark) mark = int'(out_addr) + 1;
                    end
                end
                if (out_fin) begin
                    if (wfull) begin
                        m_ovf = 1'b1;
                        mark  = 0;
                    end else if (mark > 0) begin
                        for (int i = 0; i < mark; i++) begin
                            beat_t b;
                            b.d = wbuf[i];
                            b.l = (i == mark - 1);
                            exp_q.push_back(b);
                        end
                        lens.push_back(mark);
                        com  = 1;
                        mark = 0;
                    end
                end
                if (m_valid && m_ready) begin
                    hs_cnt++;
                    if (lens.size() > 0 && hs_cnt == lens[0]) begin
                        void'(lens.pop_front());
                        hs_cnt = 0;
                        rel    = 1;
                    end
                end
                m_pend = m_pend + com - rel;
            end
        end
    end

    // Monitor: pops the scoreboard on handshakes, checks stalls, gaps and status
    initial begin : monitor
        bit            prev_stall;
        bit            prev_last_hs;
        logic [DW-1:0] prev_d;
        logic          prev_l;
        beat_t         b;
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_last_hs) chk("idle_gap", 64'(m_valid), 64'd0);
                if (prev_stall) begin
                    chk("stall_valid", 64'(m_valid), 64'd1);
                    chk("stall_data", 64'(m_data), 64'(prev_d));
                    chk("stall_last", 64'(m_last), 64'(prev_l));
                end
                chk("busy", 64'(drain_busy), 64'(m_valid));
                chk("pend", 64'(pend), 64'(m_pend));
                chk("overflow", 64'(overflow), 64'(m_ovf));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got %0h expected none (t=%0t)", m_data, $time);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", 64'(m_data), 64'(b.d));
                        chk("beat_last", 64'(m_last), 64'(b.l));
                    end
                    prev_last_hs = m_last;
                end else begin
                    prev_last_hs = 1'b0;
                end
                prev_stall = m_valid && !m_ready;
                prev_d     = m_data;
                prev_l     = m_last;
            end else begin
                prev_stall   = 1'b0;
                prev_last_hs = 1'b0;
            end
        end
    end

    // Downstream ready generator
    initial begin : ready_gen
        int ph;
        ph = 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b0;
                1: m_ready = 1'b1;
                2: begin
                    m_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                default: m_ready = ($urandom_range(0, 99) < 60);
            endcase
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input bit per, input int a, input logic [DW-1:0] d, input bit fin);
        @(posedge clk);
        #1;
        out_period = per;
        out_addr   = AW'(a);
        acc_data   = d;
        out_fin    = fin;
    endtask

    task automatic burst_seq(input int n, input logic [DW-1:0] base);
        for (int a = 0; a < n; a++) cyc(1'b1, a, base + DW'(a), a == n - 1);
        cyc(1'b0, 0, '0, 1'b0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_pend != 0 || m_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= budget) begin
            n_bad++;
            $display("FAIL %s: got timeout after %0d cycles expected drained", name, k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_pend", 64'(pend), 64'd0);
        chk("rst_busy", 64'(drain_busy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int order[DEPTH];
        int n;
        int k;
        rst_n      = 1'b0;
        out_period = 1'b0;
        out_addr   = '0;
        out_fin    = 1'b0;
        acc_data   = '0;
        ready_mode = 1;
        repeat (2) @(posedge clk);
        do_reset();

        // Single burst with commit latency check
        burst_seq(8, 32'h100);
        @(negedge clk);
        chk("lat_valid_e", 64'(m_valid), 64'd0);
        chk("lat_pend", 64'(pend), 64'd1);
        @(negedge clk);
        chk("lat_valid_e1", 64'(m_valid), 64'd1);
        chk("lat_first", 64'(m_data), 64'h100);
        wait_drain("single", 100);

        // Duplicate addresses: the second write wins
        for (int a = 0; a < 8; a++) cyc(1'b1, a, 32'hA0 + DW'(a), 1'b0);
        for (int a = 0; a < 8; a++) cyc(1'b1, a, 32'hB0 + DW'(a), a == 7);
        cyc(1'b0, 0, '0, 1'b0);
        wait_drain("dup", 100);

        // Backpressure 1,0,0 pattern
        ready_mode = 2;
        burst_seq(8, 32'h100);
        wait_drain("backpressure", 200);

        // Ping-pong fill, then overflow by a third burst
        ready_mode = 0;
        repeat (2) @(posedge clk);
        burst_seq(8, 32'h100);
        burst_seq(8, 32'h200);
        @(negedge clk);
        chk("pp_pend2", 64'(pend), 64'd2);
        burst_seq(8, 32'h300);
        @(negedge clk);
        chk("pp_overflow", 64'(overflow), 64'd1);
        ready_mode = 1;
        wait_drain("pingpong", 200);
        chk("pp_overflow_sticky", 64'(overflow), 64'd1);

        // Empty commit, then a normal burst
        do_reset();
        cyc(1'b0, 0, '0, 1'b1);
        cyc(1'b0, 0, '0, 1'b0);
        repeat (4) @(negedge clk);
        chk("empty_valid", 64'(m_valid), 64'd0);
        chk("empty_pend", 64'(pend), 64'd0);
        chk("empty_overflow", 64'(overflow), 64'd0);
        burst_seq(8, 32'h600);
        wait_drain("after_empty", 100);

        // Reset in the middle of a burst while beat 3 is presented
        burst_seq(8, 32'h500);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m_valid && m_data == 32'h502) && k < 20);
        chk("beat3_seen", 64'(m_data), 64'h502);
        do_reset();
        burst_seq(4, 32'h700);
        wait_drain("post_reset", 100);

        // Randomized bursts: shuffled addresses, duplicates, gaps, random ready
        ready_mode = 3;
        for (int bnum = 0; bnum < 25; bnum++) begin
            k = 0;
            while (m_pend >= 2 && k < 500) begin
                @(negedge clk);
                k++;
            end
            n = (bnum == 0) ? 1 : (bnum == 1) ? DEPTH : int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) order[i] = i;
            for (int i = n - 1; i > 0; i--) begin
                int j;
                int t;
                j = int'($urandom_range(0, i));
                t = order[i];
                order[i] = order[j];
                order[j] = t;
            end
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    cyc(1'b1, int'($urandom_range(0, n - 1)), $urandom, 1'b0);
                if ($urandom_range(0, 3) == 0) cyc(1'b0, 0, $urandom, 1'b0);
                cyc(1'b1, order[i], $urandom, (i == n - 1) && $urandom_range(0, 1) == 1);
            end
            if (!out_fin) cyc(1'b0, 0, '0, 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                cyc(1'b0, 0, '0, 1'b0);
                cyc(1'b0, 0, '0, 1'b1);
            end
            cyc(1'b0, 0, '0, 1'b0);
        end
        wait_drain("random", 3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
